// File: rtl/pixel_run_player_if.sv
// Instruction buffer link between the last buffer stage (master) and the
// run player (slave).
// valid/ready: a word is valid whenever buf_empty=0; the player takes it by
// raising shift_data for one cycle, and the stage advances on that same edge.
// shift_data is only ever raised while buf_empty=0.
interface pixel_run_player_if #(
   parameter int W = 18
);
   logic         buf_empty;
   logic [W-1:0] buf_data;
   logic         shift_data;

   modport master (output buf_empty, output buf_data, input shift_data);
   modport slave  (input buf_empty, input buf_data, output shift_data);
endinterface

// File: rtl/pixel_run_player.sv
// Run-length pixel player: pops {colour, run} instructions from the buffer
// chain and plays them out as RRGGBB pixels on VGA pixel-enable ticks.
// A run length of zero is a frame marker. Handles underrun (blank fill) and
// frame resynchronisation by discarding up to the next marker.
module pixel_run_player #(
   parameter int COLOR_W = 6,
   parameter int RUN_W   = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   pixel_run_player_if.slave  buf_if,
   input  logic               pixel_en,
   input  logic               frame_start,
   output logic [COLOR_W-1:0] rgb,
   output logic [7:0]         underrun_cnt,
   output logic               sync_err,
   output logic [1:0]         state_o
);

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      PLAY       = 2'd1,
      UNDERRUN   = 2'd2,
      DISCARD    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [COLOR_W-1:0] col_q, col_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic [COLOR_W-1:0] rgb_q, rgb_d;
   logic [7:0]         urun_q, urun_d;
   logic               serr_q, serr_d;
   logic               load_req;
   logic               pop;

   // Fields of the word currently offered by the last buffer stage.
   logic [COLOR_W-1:0] word_col;
   logic [RUN_W-1:0]   word_run;
   logic               word_marker;

   assign word_col    = buf_if.buf_data[COLOR_W+RUN_W-1:RUN_W];
   assign word_run    = buf_if.buf_data[RUN_W-1:0];
   assign word_marker = (word_run == '0);

   // Next-state, pixel output and pop decision.
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      run_d    = run_q;
      rgb_d    = rgb_q;
      urun_d   = urun_q;
      serr_d   = serr_q;
      load_req = 1'b0;
      pop      = 1'b0;

      // Any pixel not explicitly coloured below is blank.
      if (pixel_en) begin
         rgb_d = '0;
      end

      case (state_q)
         WAIT_FRAME: begin
            if (frame_start) begin
               if (!buf_if.buf_empty) load_req = 1'b1;
               else                   state_d  = UNDERRUN;
            end
         end
         PLAY: begin
            if (frame_start) begin
               serr_d  = 1'b1;
               state_d = DISCARD;
            end else if (pixel_en) begin
               rgb_d = col_q;
               run_d = run_q - 1'b1;
               // Last pixel of the run: fetch the next word in the same cycle
               // so back-to-back runs have no bubble.
               if (run_q == RUN_W'(1)) begin
                  if (!buf_if.buf_empty) load_req = 1'b1;
                  else                   state_d  = UNDERRUN;
               end
            end
         end
         UNDERRUN: begin
            if (frame_start) begin
               serr_d  = 1'b1;
               state_d = DISCARD;
            end else begin
               if (pixel_en && urun_q != 8'hFF) urun_d = urun_q + 8'd1;
               if (!buf_if.buf_empty) load_req = 1'b1;
            end
         end
         DISCARD: begin
            // Flush the rest of the stale frame; the marker ends the flush.
            if (!buf_if.buf_empty) begin
               pop = 1'b1;
               if (word_marker) state_d = UNDERRUN;
            end
         end
         default: state_d = WAIT_FRAME;
      endcase

      if (load_req) begin
         pop = 1'b1;
         if (word_marker) begin
            state_d = WAIT_FRAME;
         end else begin
            col_d   = word_col;
            run_d   = word_run;
            state_d = PLAY;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= WAIT_FRAME;
         col_q   <= '0;
         run_q   <= '0;
         rgb_q   <= '0;
         urun_q  <= '0;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         run_q   <= run_d;
         rgb_q   <= rgb_d;
         urun_q  <= urun_d;
         serr_q  <= serr_d;
      end
   end

   assign buf_if.shift_data = pop & rst_n;
   assign rgb               = rgb_q;
   assign underrun_cnt      = urun_q;
   assign sync_err          = serr_q;
   assign state_o           = state_q;

endmodule

// File: tb/tb_pixel_run_player.sv
// Directed bench for pixel_run_player with a small queue model of the buffer.
module tb_pixel_run_player;

   localparam logic [1:0] S_WAIT = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_UNDR = 2'd2;
   localparam logic [1:0] S_DISC = 2'd3;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pixel_en = 1'b0;
   logic       frame_start = 1'b0;
   logic [5:0] rgb;
   logic [7:0] underrun_cnt;
   logic       sync_err;
   logic [1:0] state_o;

   always #5 clk = ~clk;

   pixel_run_player_if bif ();

   pixel_run_player dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .buf_if       (bif.slave),
      .pixel_en     (pixel_en),
      .frame_start  (frame_start),
      .rgb          (rgb),
      .underrun_cnt (underrun_cnt),
      .sync_err     (sync_err),
      .state_o      (state_o)
   );

   // ---------------- buffer model / scoreboard ----------------
   logic [17:0] buf_q[$];
   int          pops;
   int          checks;
   int          errors;

   function automatic logic [17:0] w(input logic [5:0] c, input logic [11:0] r);
      return {c, r};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: inputs applied at the negedge, pop sampled just before the
   // posedge, model queue advanced afterwards; returns at the next negedge.
   task automatic tick(input logic pe, input logic fs);
      logic popped;
      logic was_empty;
      pixel_en      = pe;
      frame_start   = fs;
      bif.buf_empty = (buf_q.size() == 0);
      bif.buf_data  = (buf_q.size() != 0) ? buf_q[0] : 18'h0;
      #1;
      popped    = bif.shift_data;
      was_empty = bif.buf_empty;
      chk("pop_on_empty", {31'd0, popped & was_empty}, 32'd0);
      @(negedge clk);
      if (popped && !was_empty) begin
         void'(buf_q.pop_front());
         pops++;
      end
      pixel_en    = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic do_reset();
      buf_q.delete();
      rst_n = 1'b0;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      rst_n = 1'b1;
      pops = 0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      checks = 0;
      errors = 0;
      pops   = 0;
      bif.buf_empty = 1'b1;
      bif.buf_data  = '0;
      @(negedge clk);
      do_reset();

      chk("rst_rgb", {26'd0, rgb}, 32'd0);
      chk("rst_state", {30'd0, state_o}, {30'd0, S_WAIT});
      chk("rst_urun", {24'd0, underrun_cnt}, 32'd0);
      chk("rst_serr", {31'd0, sync_err}, 32'd0);

      // 1: back-to-back runs, pixel every cycle
      buf_q.push_back(w(6'h3F, 12'd3));
      buf_q.push_back(w(6'h05, 12'd2));
      tick(1'b0, 1'b1);
      chk("t1_pop_fs", pops, 1);
      chk("t1_state", {30'd0, state_o}, {30'd0, S_PLAY});
      tick(1'b1, 1'b0); chk("t1_px1", {26'd0, rgb}, 32'h3F);
      tick(1'b1, 1'b0); chk("t1_px2", {26'd0, rgb}, 32'h3F);
      chk("t1_nopop", pops, 1);
      tick(1'b1, 1'b0); chk("t1_px3", {26'd0, rgb}, 32'h3F);
      chk("t1_pop_px3", pops, 2);
      tick(1'b1, 1'b0); chk("t1_px4", {26'd0, rgb}, 32'h05);
      tick(1'b1, 1'b0); chk("t1_px5", {26'd0, rgb}, 32'h05);
      chk("t1_undr", {30'd0, state_o}, {30'd0, S_UNDR});

      // 2: sparse pixel ticks, rgb holds between ticks
      do_reset();
      buf_q.push_back(w(6'h2A, 12'd2));
      buf_q.push_back(w(6'h15, 12'd1));
      tick(1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         tick((i % 4) == 0, 1'b0);
         chk("t2_hold", {26'd0, rgb}, 32'h2A);
         if (i == 3) chk("t2_one_pop", pops, 1);
      end
      chk("t2_pop_end", pops, 2);
      tick(1'b1, 1'b0); chk("t2_next", {26'd0, rgb}, 32'h15);

      // 3: underrun blank fill, then resume with a new run
      do_reset();
      buf_q.push_back(w(6'h0C, 12'd1));
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b0); chk("t3_px0", {26'd0, rgb}, 32'h0C);
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'b0);
         chk("t3_blank", {26'd0, rgb}, 32'h00);
      end
      chk("t3_urun", {24'd0, underrun_cnt}, 32'd4);
      buf_q.push_back(w(6'h30, 12'd1));
      tick(1'b0, 1'b0);
      chk("t3_reload", {30'd0, state_o}, {30'd0, S_PLAY});
      tick(1'b1, 1'b0); chk("t3_px5", {26'd0, rgb}, 32'h30);
      chk("t3_urun_end", {24'd0, underrun_cnt}, 32'd4);

      // 4: marker ends the frame, no more pops until frame_start
      do_reset();
      buf_q.push_back(w(6'h11, 12'd2));
      buf_q.push_back(w(6'h00, 12'd0));
      buf_q.push_back(w(6'h22, 12'd4));
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b0); chk("t4_px0", {26'd0, rgb}, 32'h11);
      tick(1'b1, 1'b0); chk("t4_px1", {26'd0, rgb}, 32'h11);
      chk("t4_marker_pop", pops, 2);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0);
         chk("t4_blank", {26'd0, rgb}, 32'h00);
      end
      chk("t4_no_pops", pops, 2);
      chk("t4_state", {30'd0, state_o}, {30'd0, S_WAIT});
      chk("t4_urun", {24'd0, underrun_cnt}, 32'd0);

      // 5: frame_start mid-run -> discard to marker, resync on next word
      do_reset();
      buf_q.push_back(w(6'h07, 12'd100));
      tick(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
      chk("t5_play", {26'd0, rgb}, 32'h07);
      buf_q.push_back(w(6'h07, 12'd5));
      buf_q.push_back(w(6'h00, 12'd0));
      buf_q.push_back(w(6'h3C, 12'd1));
      tick(1'b1, 1'b1);
      chk("t5_fs_blank", {26'd0, rgb}, 32'h00);
      chk("t5_serr", {31'd0, sync_err}, 32'd1);
      chk("t5_disc", {30'd0, state_o}, {30'd0, S_DISC});
      chk("t5_fs_nopop", pops, 1);
      chk("t5_fs_urun", {24'd0, underrun_cnt}, 32'd0);
      tick(1'b0, 1'b1);
      chk("t5_disc_fs_ign", {30'd0, state_o}, {30'd0, S_DISC});
      tick(1'b0, 1'b0);
      chk("t5_marker", {30'd0, state_o}, {30'd0, S_UNDR});
      chk("t5_two_disc", pops, 3);
      tick(1'b0, 1'b0);
      chk("t5_load", pops, 4);
      tick(1'b1, 1'b0); chk("t5_px", {26'd0, rgb}, 32'h3C);
      chk("t5_serr_sticky", {31'd0, sync_err}, 32'd1);

      // 6: reset mid-run
      do_reset();
      buf_q.push_back(w(6'h2A, 12'd50));
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      chk("t6_play", {26'd0, rgb}, 32'h2A);
      rst_n = 1'b0;
      buf_q.push_back(w(6'h33, 12'd1));
      tick(1'b1, 1'b0);
      rst_n = 1'b1;
      chk("t6_rgb", {26'd0, rgb}, 32'd0);
      chk("t6_state", {30'd0, state_o}, {30'd0, S_WAIT});
      chk("t6_rst_nopop", pops, 1);
      tick(1'b1, 1'b0);
      chk("t6_wait_rgb", {26'd0, rgb}, 32'd0);
      chk("t6_wait_nopop", pops, 1);
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b0);
      chk("t6_resume", {26'd0, rgb}, 32'h33);

      // Underrun counter saturation, then frame_start in UNDERRUN
      do_reset();
      tick(1'b0, 1'b1);
      chk("sat_state", {30'd0, state_o}, {30'd0, S_UNDR});
      for (int i = 0; i < 260; i++) tick(1'b1, 1'b0);
      chk("sat_urun", {24'd0, underrun_cnt}, 32'd255);
      chk("sat_serr0", {31'd0, sync_err}, 32'd0);
      tick(1'b0, 1'b1);
      chk("undr_fs_serr", {31'd0, sync_err}, 32'd1);
      chk("undr_fs_disc", {30'd0, state_o}, {30'd0, S_DISC});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
